// File: rtl/key_remap_if.sv
// Bundle between the key-remap sequencer and its environment: session
// control and debounced keys in, map-RAM write side and status out.
interface key_remap_if #(
  parameter int NOTE_BITS = 7,
  parameter int LEN_BITS  = 4
);
  localparam int MAX_BITS = (NOTE_BITS > LEN_BITS) ? NOTE_BITS : LEN_BITS;
  localparam int SLOT_W   = (MAX_BITS > 2) ? $clog2(MAX_BITS) : 1;

  logic                 start;
  logic                 sel_len;
  logic                 cancel;
  logic [NOTE_BITS-1:0] note_keys;
  logic [LEN_BITS-1:0]  len_keys;
  logic                 rw0;
  logic [NOTE_BITS-1:0] addr0;
  logic [NOTE_BITS-1:0] in0;
  logic                 rw1;
  logic [LEN_BITS-1:0]  addr1;
  logic [LEN_BITS-1:0]  in1;
  logic                 busy;
  logic [SLOT_W-1:0]    slot;
  logic                 done;
  logic                 aborted;
  logic                 err;

  modport master (
    input  start, sel_len, cancel, note_keys, len_keys,
    output rw0, addr0, in0, rw1, addr1, in1, busy, slot, done, aborted, err
  );

  modport slave (
    output start, sel_len, cancel, note_keys, len_keys,
    input  rw0, addr0, in0, rw1, addr1, in1, busy, slot, done, aborted, err
  );
endinterface

// File: rtl/key_remap_ctrl.sv
// Key-remap session sequencer: walks every slot of the selected key-map table,
// accepts one unique single-key press per slot and issues a one-cycle RAM write.
module key_remap_ctrl #(
  parameter int NOTE_BITS = 7,
  parameter int LEN_BITS  = 4,
  parameter int TIMEOUT   = 50_000_000
) (
  input logic         clk,
  input logic         rst,
  key_remap_if.master bus
);
  localparam int MAX_BITS = (NOTE_BITS > LEN_BITS) ? NOTE_BITS : LEN_BITS;
  localparam int SLOT_W   = (MAX_BITS > 2) ? $clog2(MAX_BITS) : 1;
  localparam int CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_REL   = 3'd1,
    S_WAIT_PRESS = 3'd2,
    S_WRITE      = 3'd3,
    S_DONE       = 3'd4
  } state_t;

  state_t               state_r, state_n;
  logic                 tbl_r, tbl_n;
  logic [SLOT_W-1:0]    slot_r, slot_n, last_slot_s;
  logic [MAX_BITS-1:0]  used_r, used_n, cap_r, cap_n;
  logic [MAX_BITS-1:0]  key_s, slot_hot_s;
  logic [CNT_W-1:0]     cnt_r;
  logic                 timeout_s, err_n, aborted_n, write_n;
  logic                 wr_note_s, wr_len_s;
  logic                 rw0_r, rw1_r, busy_r, done_r, aborted_r, err_r;
  logic [NOTE_BITS-1:0] addr0_r, in0_r;
  logic [LEN_BITS-1:0]  addr1_r, in1_r;

  function automatic logic is_onehot(input logic [MAX_BITS-1:0] v);
    return (v != MAX_BITS'(0)) && ((v & (v - MAX_BITS'(1))) == MAX_BITS'(0));
  endfunction

  assign key_s       = tbl_r ? MAX_BITS'(bus.len_keys) : MAX_BITS'(bus.note_keys);
  assign last_slot_s = tbl_r ? SLOT_W'(LEN_BITS - 1) : SLOT_W'(NOTE_BITS - 1);
  assign timeout_s   = (cnt_r == CNT_W'(TIMEOUT - 1));

  // Next-state and session-register update; cancel outranks every other move.
  always_comb begin
    state_n   = state_r;
    tbl_n     = tbl_r;
    slot_n    = slot_r;
    used_n    = used_r;
    cap_n     = cap_r;
    err_n     = 1'b0;
    aborted_n = 1'b0;
    if ((state_r != S_IDLE) && bus.cancel) begin
      state_n   = S_IDLE;
      aborted_n = 1'b1;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (bus.start) begin
            tbl_n   = bus.sel_len;
            slot_n  = SLOT_W'(0);
            used_n  = MAX_BITS'(0);
            state_n = S_WAIT_REL;
          end else begin
            state_n = S_IDLE;
          end
        end
        S_WAIT_REL: begin
          if (timeout_s) begin
            state_n   = S_IDLE;
            aborted_n = 1'b1;
            err_n     = 1'b1;
          end else if (key_s == MAX_BITS'(0)) begin
            state_n = S_WAIT_PRESS;
          end else begin
            state_n = S_WAIT_REL;
          end
        end
        S_WAIT_PRESS: begin
          if (timeout_s) begin
            state_n   = S_IDLE;
            aborted_n = 1'b1;
            err_n     = 1'b1;
          end else if (key_s == MAX_BITS'(0)) begin
            state_n = S_WAIT_PRESS;
          end else if (!is_onehot(key_s) || ((key_s & used_r) != MAX_BITS'(0))) begin
            err_n   = 1'b1;
            state_n = S_WAIT_REL;
          end else begin
            cap_n   = key_s;
            state_n = S_WRITE;
          end
        end
        S_WRITE: begin
          used_n = used_r | cap_r;
          if (slot_r == last_slot_s) begin
            state_n = S_DONE;
          end else begin
            slot_n  = slot_r + SLOT_W'(1);
            state_n = S_WAIT_REL;
          end
        end
        S_DONE: begin
          state_n = S_IDLE;
        end
        default: begin
          state_n = S_IDLE;
        end
      endcase
    end
  end

  assign write_n    = (state_n == S_WRITE);
  assign wr_note_s  = write_n & ~tbl_n;
  assign wr_len_s   = write_n & tbl_n;
  assign slot_hot_s = MAX_BITS'(1) << slot_n;

  // Session state registers; the idle counter restarts on every state change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
      tbl_r   <= 1'b0;
      slot_r  <= SLOT_W'(0);
      used_r  <= MAX_BITS'(0);
      cap_r   <= MAX_BITS'(0);
      cnt_r   <= CNT_W'(0);
    end else begin
      state_r <= state_n;
      tbl_r   <= tbl_n;
      slot_r  <= slot_n;
      used_r  <= used_n;
      cap_r   <= cap_n;
      if (state_n != state_r) begin
        cnt_r <= CNT_W'(0);
      end else if ((state_r == S_WAIT_REL) || (state_r == S_WAIT_PRESS)) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end else begin
        cnt_r <= CNT_W'(0);
      end
    end
  end

  // Outputs are registered from next-state values so they align with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rw0_r     <= 1'b0;
      addr0_r   <= NOTE_BITS'(0);
      in0_r     <= NOTE_BITS'(0);
      rw1_r     <= 1'b0;
      addr1_r   <= LEN_BITS'(0);
      in1_r     <= LEN_BITS'(0);
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      aborted_r <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      rw0_r     <= wr_note_s;
      addr0_r   <= wr_note_s ? slot_hot_s[NOTE_BITS-1:0] : NOTE_BITS'(0);
      in0_r     <= wr_note_s ? cap_n[NOTE_BITS-1:0] : NOTE_BITS'(0);
      rw1_r     <= wr_len_s;
      addr1_r   <= wr_len_s ? slot_hot_s[LEN_BITS-1:0] : LEN_BITS'(0);
      in1_r     <= wr_len_s ? cap_n[LEN_BITS-1:0] : LEN_BITS'(0);
      busy_r    <= (state_n != S_IDLE);
      done_r    <= (state_n == S_DONE);
      aborted_r <= aborted_n;
      err_r     <= err_n;
    end
  end

  assign bus.rw0     = rw0_r;
  assign bus.addr0   = addr0_r;
  assign bus.in0     = in0_r;
  assign bus.rw1     = rw1_r;
  assign bus.addr1   = addr1_r;
  assign bus.in1     = in1_r;
  assign bus.busy    = busy_r;
  assign bus.slot    = slot_r;
  assign bus.done    = done_r;
  assign bus.aborted = aborted_r;
  assign bus.err     = err_r;
endmodule

// File: tb/tb_key_remap_ctrl.sv
// Scoreboard bench for key_remap_ctrl: a session-level reference model predicts
// every output event (writes, pulses, busy edges) with its cycle; a monitor compares.
module tb_key_remap_ctrl;
  localparam int NB = 7;
  localparam int LB = 4;
  localparam int TO = 16;
  localparam int SW = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  key_remap_if #(.NOTE_BITS(NB), .LEN_BITS(LB)) kif ();
  key_remap_ctrl #(.NOTE_BITS(NB), .LEN_BITS(LB), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .bus(kif)
  );

  typedef struct {
    int stamp;
    bit rw0; int addr0; int in0;
    bit rw1; int addr1; int in1;
    bit done; bit aborted; bit err; bit busy;
    int slot;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: a session is "on"; phase 0 waits for release, 1 waits for a
  // press, 2 is the write cycle, 3 is the completion cycle.
  bit m_on, m_tbl, m_prev_busy;
  int m_phase, m_slot, m_used, m_cap, m_wait;

  function automatic void chk(string name, longint act, longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endfunction

  function automatic logic [30:0] pack_dut();
    return {kif.rw0, kif.addr0, kif.in0, kif.rw1, kif.addr1, kif.in1,
            kif.done, kif.aborted, kif.err, kif.busy, kif.slot};
  endfunction

  function automatic logic [30:0] pack_exp(ev_t e);
    return {e.rw0, NB'(e.addr0), NB'(e.in0), e.rw1, LB'(e.addr1), LB'(e.in1),
            e.done, e.aborted, e.err, e.busy, SW'(e.slot)};
  endfunction

  function automatic void model_reset();
    m_on = 0; m_tbl = 0; m_prev_busy = 0;
    m_phase = 0; m_slot = 0; m_used = 0; m_cap = 0; m_wait = 0;
  endfunction

  function automatic void model_cycle(bit st, bit sel, bit cn, int nk, int lk);
    ev_t e = '{default: 0};
    int  k = m_tbl ? lk : nk;
    int  n = m_tbl ? LB : NB;
    e.stamp = cyc + 1;
    if (!m_on) begin
      if (st) begin
        m_on = 1; m_tbl = sel; m_slot = 0; m_used = 0; m_phase = 0; m_wait = 0;
      end
    end else if (cn) begin
      m_on = 0; e.aborted = 1;
    end else if (m_phase <= 1 && m_wait == TO - 1) begin
      m_on = 0; e.aborted = 1; e.err = 1;
    end else if (m_phase == 0) begin
      if (k == 0) begin m_phase = 1; m_wait = 0; end
      else m_wait++;
    end else if (m_phase == 1) begin
      if (k == 0) m_wait++;
      else if ($countones(k) != 1 || (k & m_used) != 0) begin
        e.err = 1; m_phase = 0; m_wait = 0;
      end else begin
        m_cap = k; m_phase = 2;
      end
    end else if (m_phase == 2) begin
      m_used |= m_cap;
      if (m_slot == n - 1) m_phase = 3;
      else begin m_slot++; m_phase = 0; m_wait = 0; end
    end else begin
      m_on = 0;
    end
    if (m_on && m_phase == 2) begin
      if (m_tbl) begin e.rw1 = 1; e.addr1 = 1 << m_slot; e.in1 = m_cap; end
      else       begin e.rw0 = 1; e.addr0 = 1 << m_slot; e.in0 = m_cap; end
    end
    e.done = m_on && m_phase == 3;
    e.busy = m_on;
    e.slot = m_slot;
    if (e.rw0 || e.rw1 || e.done || e.aborted || e.err || (e.busy != m_prev_busy))
      exp_q.push_back(e);
    m_prev_busy = e.busy;
  endfunction

  // Monitor: any pulse or busy edge is an event; it must match the oldest prediction.
  initial begin : monitor
    bit  prev_busy;
    ev_t e;
    prev_busy = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_busy = 0;
      end else begin
        while (exp_q.size() > 0 && exp_q[0].stamp < cyc) begin
          e = exp_q.pop_front();
          chk("missing_event_cycle", e.stamp, cyc);
        end
        if (kif.rw0 || kif.rw1 || kif.done || kif.aborted || kif.err || (kif.busy != prev_busy)) begin
          prev_busy = kif.busy;
          if (exp_q.size() == 0) begin
            chk("unexpected_event", pack_dut(), 0);
          end else begin
            e = exp_q.pop_front();
            chk("event_cycle", cyc, e.stamp);
            chk("event_outputs", pack_dut(), pack_exp(e));
          end
        end
      end
    end
  end

  task automatic step(input bit st, input bit sel, input bit cn, input int nk, input int lk);
    nk = nk & ((1 << NB) - 1);
    lk = lk & ((1 << LB) - 1);
    kif.start = st; kif.sel_len = sel; kif.cancel = cn;
    kif.note_keys = NB'(nk); kif.len_keys = LB'(lk);
    model_cycle(st, sel, cn, nk, lk);
    @(posedge clk); #2;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0);
  endtask

  // Release for 1-2 cycles, then hold the key for the given number of cycles.
  task automatic press(input bit tbl, input int key, input int hold);
    idle(1 + $urandom_range(1));
    repeat (hold) step(0, 0, 0, tbl ? 0 : key, tbl ? key : 0);
  endtask

  task automatic idle_until_press_wait();
    for (int i = 0; i < 8 && !(m_on && m_phase == 1); i++) idle(1);
  endtask

  task automatic mid_reset();
    kif.start = 0; kif.cancel = 0; kif.note_keys = '0; kif.len_keys = '0;
    @(negedge clk); #1 rst = 1'b1; #1;
    chk("reset_mid_session_outputs", pack_dut(), 0);
    @(posedge clk); @(posedge clk); #2 rst = 1'b0;
    model_reset();
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stimulus
    int nk, lk;
    kif.start = 0; kif.sel_len = 0; kif.cancel = 0; kif.note_keys = '0; kif.len_keys = '0;
    model_reset();
    #1 rst = 1'b1; #1;
    chk("reset_state_outputs", pack_dut(), 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // Full note-table session, highest key first; held keys exercise the release rule.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < NB; i++) press(0, 8'h40 >> i, 1 + $urandom_range(3));
    idle(4);

    // Length table: chord and duplicate rejection at slot 1.
    step(1, 1, 0, 0, 0);
    press(1, 4'h1, 2);
    press(1, 4'h3, 1);
    press(1, 4'h1, 1);
    press(1, 4'h4, 2);
    press(1, 4'h2, 1);
    press(1, 4'h8, 3);
    idle(4);

    // Cancel sampled together with a valid press: the write must not appear.
    step(1, 0, 0, 0, 0);
    press(0, 8'h10, 1);
    idle_until_press_wait();
    step(0, 0, 1, 8'h20, 0);
    idle(3);

    // Timeout with no press at all.
    step(1, 1, 0, 0, 0);
    idle(22);

    // Asynchronous reset while waiting for a press, then a fresh session.
    step(1, 0, 0, 0, 0);
    idle_until_press_wait();
    mid_reset();
    step(1, 1, 0, 0, 0);
    press(1, 4'h2, 2);
    idle(2);

    // Randomised traffic: mostly single keys, occasional chords, starts and cancels.
    nk = 0; lk = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(2) == 0) begin
        case ($urandom_range(9))
          0, 1, 2, 3, 4: begin nk = 0; lk = 0; end
          9:             begin nk = $urandom_range(127); lk = $urandom_range(15); end
          default:       begin nk = 1 << $urandom_range(NB - 1); lk = 1 << $urandom_range(LB - 1); end
        endcase
      end
      step($urandom_range(11) == 0, $urandom_range(1) == 1, $urandom_range(79) == 0, nk, lk);
    end

    step(0, 0, 1, 0, 0);
    idle(3);
    @(negedge clk); #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
